// File: rtl/mem2io_pkg.sv
// Shared types and helpers for the SLC-3 memory / I-O bridge.
package mem2io_pkg;

  // Bridge sequencing: accept a request, run the SRAM access, pulse Ready, wait for strobe release.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Default top-of-memory I/O address; the top slices this down to its address width.
  localparam logic [63:0] IO_ADDR_ALL_ONES = '1;

  // Number of DW-bit words needed to hold n_hex 4-bit digits.
  function automatic int hex_words(input int n_hex, input int dw);
    return (4 * n_hex + dw - 1) / dw;
  endfunction

  // Index width for an n-entry bank, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem2io_ws_hex_bank.sv
// Bank of HEX_WORDS x DW registers backing the hex display, stored flat as
// 4*N_HEX bits so excess bits of the last word never exist.
module hex_bank
  import mem2io_pkg::*;
#(
  parameter int DW        = 16,
  parameter int N_HEX     = 4,
  parameter int HEX_WORDS = hex_words(N_HEX, DW),
  parameter int IW        = idx_width(HEX_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata,
  output logic [4*N_HEX-1:0] hex_out
);

  logic [4*N_HEX-1:0] hex_q, hex_d;

  // Word write and word read: bit b of the flat vector belongs to word b/DW, lane b%DW.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hex_d = hex_q;
    rdata = '0;
    for (int b = 0; b < 4 * N_HEX; b++) begin
      if (b / DW == int'(idx)) begin
        if (we) hex_d[b] = wdata[b % DW];
        rdata[b % DW] = hex_q[b];
      end
    end
  end

  // Digit storage; cleared on reset so the display starts blank.
  always_ff @(posedge clk) begin
    // NOTE: this storage is reset (unlike a RAM) because its contents are a visible output;
    // state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) hex_q <= '0;
    else       hex_q <= hex_d;
  end

  assign hex_out = hex_q;

endmodule

// File: rtl/mem2io_ws.sv
// SLC-3 memory / I-O bridge: decodes switch and hex-digit addresses at the top
// of memory, forwards everything else to SRAM with WAIT_STATES extra cycles,
// and returns a one-cycle Ready pulse per access.
module mem2io_ws
  import mem2io_pkg::*;
#(
  parameter int             DW          = 16,
  parameter int             AW          = 16,
  parameter int             WAIT_STATES = 2,
  parameter int             N_HEX       = 4,
  parameter int             N_SW        = 10,
  parameter logic [AW-1:0]  IO_ADDR     = IO_ADDR_ALL_ONES[AW-1:0]
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [AW-1:0]       ADDR,
  input  logic [DW-1:0]       Data_from_CPU,
  output logic [DW-1:0]       Data_to_CPU,
  input  logic                Mem_OE,
  input  logic                Mem_WE,
  output logic                Ready,
  input  logic [N_SW-1:0]     Switches,
  output logic [4*N_HEX-1:0]  Hex_Out,
  output logic [AW-1:0]       SRAM_ADDR,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic [DW-1:0]       Data_to_SRAM,
  input  logic [DW-1:0]       Data_from_SRAM
);

  localparam int         HEX_WORDS = hex_words(N_HEX, DW);
  localparam int         IW        = idx_width(HEX_WORDS);
  localparam logic [3:0] WS        = 4'(WAIT_STATES);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;

  logic            hex_we;
  logic [DW-1:0]   hex_rdata;

  // Address decode: hex word k lives at IO_ADDR-k, so the distance below IO_ADDR is the word index.
  logic [AW-1:0]   io_off;
  logic            is_io;
  logic [IW-1:0]   hex_idx;
  logic            wr_req, rd_req;
  logic [DW-1:0]   sw_ext;

  assign io_off  = IO_ADDR - ADDR;
  assign is_io   = io_off < AW'(HEX_WORDS);
  assign hex_idx = io_off[IW-1:0];
  assign wr_req  = !Mem_WE;              // write wins when both strobes are low
  assign rd_req  = !Mem_OE && Mem_WE;
  assign sw_ext  = DW'(Switches);

  hex_bank #(
    .DW        (DW),
    .N_HEX     (N_HEX),
    .HEX_WORDS (HEX_WORDS),
    .IW        (IW)
  ) u_hex_bank (
    .clk     (Clk),
    .reset   (Reset),
    .we      (hex_we),
    .idx     (hex_idx),
    .wdata   (Data_from_CPU),
    .rdata   (hex_rdata),
    .hex_out (Hex_Out)
  );

  // Next-state, wait counter, SRAM strobes and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    hex_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          if (is_io) begin
            hex_we  = wr_req;
            if (rd_req) rdata_d = (io_off == '0) ? sw_ext : hex_rdata;
            state_d = DONE;
          end else begin
            addr_d  = ADDR;
            if (wr_req) wdat_d = Data_from_CPU;
            oe_n_d  = !rd_req;
            we_n_d  = !wr_req;
            cnt_d   = WS;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!oe_n_q) rdata_d = Data_from_SRAM;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = HOLD;
      // A strobe still held after Ready must not start a second access.
      HOLD:    if (Mem_OE && Mem_WE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign Ready        = (state_q == DONE);
  assign Data_to_CPU  = rdata_q;
  assign SRAM_ADDR    = addr_q;
  assign SRAM_OE_N    = oe_n_q;
  assign SRAM_WE_N    = we_n_q;
  assign Data_to_SRAM = wdat_q;

endmodule

// File: tb/tb_mem2io_ws.sv
// Scoreboard bench for mem2io_ws: a driver issues accesses and predicts the
// response from a simple memory / digit model; a monitor checks each Ready.
module tb_mem2io_ws;

  localparam int          DW = 16, AW = 16, WS = 2, N_HEX = 8, N_SW = 10;
  localparam int          HEX_WORDS = 2;
  localparam logic [15:0] IO = 16'hFFFF;

  logic              Clk, Reset;
  logic [AW-1:0]     ADDR;
  logic [DW-1:0]     Data_from_CPU, Data_to_CPU;
  logic              Mem_OE, Mem_WE, Ready;
  logic [N_SW-1:0]   Switches;
  logic [4*N_HEX-1:0] Hex_Out;
  logic [AW-1:0]     SRAM_ADDR;
  logic              SRAM_OE_N, SRAM_WE_N;
  logic [DW-1:0]     Data_to_SRAM, Data_from_SRAM;

  mem2io_ws #(
    .DW(DW), .AW(AW), .WAIT_STATES(WS), .N_HEX(N_HEX), .N_SW(N_SW), .IO_ADDR(IO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
    .Data_to_CPU(Data_to_CPU), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Ready(Ready),
    .Switches(Switches), .Hex_Out(Hex_Out), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM)
  );

  // Physical SRAM (256 words, low address byte) and the model's own view of memory.
  logic [15:0] sram    [256];
  logic [15:0] ref_mem [256];
  assign Data_from_SRAM = SRAM_OE_N ? 16'hDEAD : sram[SRAM_ADDR[7:0]];
  always @(posedge Clk) if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= Data_to_SRAM;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          is_wr;
    bit          is_io;
    int          e0;
    logic [15:0] exp_rd;
    logic [31:0] exp_hex;
  } txn_t;

  txn_t        q[$];
  int          checks = 0, errors = 0;
  int          oe_cnt = 0, we_cnt = 0;
  logic [3:0]  digits [N_HEX];
  logic [15:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hex_flat();
    logic [31:0] v;
    for (int d = 0; d < N_HEX; d++) v[4*d +: 4] = digits[d];
    return v;
  endfunction

  // One CPU access: predict, hold strobes until Ready (plus 'hold' cycles), then release.
  task automatic issue(input logic [15:0] addr, input logic [15:0] wdata,
                       input bit oe_n, input bit we_n, input logic [9:0] sw, input int hold);
    txn_t        t;
    logic [15:0] off;
    int          k;
    bit          got;
    @(negedge Clk);
    ADDR = addr; Data_from_CPU = wdata; Mem_OE = oe_n; Mem_WE = we_n; Switches = sw;
    off     = IO - addr;
    t.addr  = addr;
    t.wdata = wdata;
    t.is_wr = !we_n;
    t.is_io = off < 16'(HEX_WORDS);
    k       = int'(off);
    if (t.is_wr) begin
      if (t.is_io) begin
        for (int n = 0; n < 4; n++)
          if (4 * k + n < N_HEX) digits[4*k+n] = wdata[4*n +: 4];
      end else begin
        ref_mem[addr[7:0]] = wdata;
      end
    end else if (t.is_io) begin
      if (k == 0) last_rd = {6'b0, sw};
      else for (int n = 0; n < 4; n++) last_rd[4*n +: 4] = (4 * k + n < N_HEX) ? digits[4*k+n] : 4'h0;
    end else begin
      last_rd = ref_mem[addr[7:0]];
    end
    t.exp_rd  = last_rd;
    t.exp_hex = hex_flat();
    t.e0      = cyc + 1;
    q.push_back(t);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      got = Ready;
    end
    if (!got) begin
      check("ready_timeout", 32'(got), 32'd1);
      q.delete();
    end
    repeat (hold) begin
      @(negedge Clk);
      ADDR = 16'($urandom); Data_from_CPU = 16'($urandom);
    end
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    @(negedge Clk);
    repeat ($urandom_range(0, 2)) @(negedge Clk);
  endtask

  // Monitor: strobe-phase address/data stability, and full response check at each Ready.
  initial begin
    txn_t t;
    forever begin
      @(negedge Clk);
      if (!SRAM_OE_N) oe_cnt++;
      if (!SRAM_WE_N) we_cnt++;
      if (!SRAM_OE_N || !SRAM_WE_N) begin
        if (q.size() == 0) check("stray_strobe", {30'b0, SRAM_OE_N, SRAM_WE_N}, 32'd3);
        else begin
          check("sram_addr", 32'(SRAM_ADDR), 32'(q[0].addr));
          if (q[0].is_wr) check("sram_wdata", 32'(Data_to_SRAM), 32'(q[0].wdata));
        end
      end
      if (Ready) begin
        if (q.size() == 0) check("spurious_ready", 32'(Ready), 32'd0);
        else begin
          t = q.pop_front();
          check("ready_cycle", 32'(cyc), 32'(t.e0 + (t.is_io ? 0 : WS + 1)));
          check("rd_data", 32'(Data_to_CPU), 32'(t.exp_rd));
          check("hex_out", Hex_Out, t.exp_hex);
          check("oe_cycles", 32'(oe_cnt), 32'((!t.is_io && !t.is_wr) ? WS + 1 : 0));
          check("we_cycles", 32'(we_cnt), 32'((!t.is_io && t.is_wr) ? WS + 1 : 0));
          if (t.is_wr && !t.is_io) check("sram_mem", 32'(sram[t.addr[7:0]]), 32'(t.wdata));
        end
        oe_cnt = 0; we_cnt = 0;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},     32'(Ready),        32'd0);
    check({tag, "_rd_data"},   32'(Data_to_CPU),  32'd0);
    check({tag, "_hex"},       Hex_Out,           32'd0);
    check({tag, "_oe_n"},      32'(SRAM_OE_N),    32'd1);
    check({tag, "_we_n"},      32'(SRAM_WE_N),    32'd1);
    check({tag, "_sram_addr"}, 32'(SRAM_ADDR),    32'd0);
    check({tag, "_sram_wd"},   32'(Data_to_SRAM), 32'd0);
  endtask

  // Start an SRAM read, then assert Reset during its second ACCESS cycle.
  task automatic abort_read(input logic [15:0] addr);
    txn_t t;
    @(negedge Clk);
    ADDR = addr; Mem_OE = 1'b0; Mem_WE = 1'b1;
    t.addr = addr; t.wdata = '0; t.is_wr = 1'b0; t.is_io = 1'b0;
    t.e0 = cyc + 1; t.exp_rd = '0; t.exp_hex = '0;
    q.push_back(t);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    Reset = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    q.delete();
    oe_cnt = 0; we_cnt = 0;
    for (int d = 0; d < N_HEX; d++) digits[d] = 4'h0;
    last_rd = '0;
    @(negedge Clk);
    check_reset_state("abort");
    Reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      check("abort_no_ready", 32'(Ready), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[8'h10] = 16'h1234; ref_mem[8'h10] = 16'h1234;
    for (int d = 0; d < N_HEX; d++) digits[d] = 4'h0;
    Reset = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    ADDR = '0; Data_from_CPU = '0; Switches = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_state("reset");
    Reset = 1'b0;

    issue(16'h0010, 16'h0000, 1'b0, 1'b1, 10'h000, 0);   // SRAM read
    issue(16'h0020, 16'hBEEF, 1'b1, 1'b0, 10'h000, 0);   // SRAM write
    issue(16'hFFFF, 16'h0000, 1'b0, 1'b1, 10'h2A5, 0);   // switch read
    issue(16'hFFFF, 16'hC0DE, 1'b1, 1'b0, 10'h000, 0);   // hex word 0
    issue(16'hFFFE, 16'h1234, 1'b1, 1'b0, 10'h000, 0);   // hex word 1
    issue(16'hFFFE, 16'h0000, 1'b0, 1'b1, 10'h3FF, 0);   // hex word 1 read-back
    issue(16'hFFFD, 16'h7777, 1'b1, 1'b0, 10'h000, 0);   // just below the hex words: SRAM
    issue(16'h0040, 16'h0000, 1'b0, 1'b1, 10'h000, 10);  // strobe held long after Ready
    issue(16'h0040, 16'h0000, 1'b0, 1'b1, 10'h000, 0);
    issue(16'h0030, 16'h5A5A, 1'b0, 1'b0, 10'h000, 0);   // both strobes: write wins
    issue(16'h0030, 16'h0000, 1'b0, 1'b1, 10'h000, 0);
    abort_read(16'h0050);
    issue(16'h0050, 16'h0000, 1'b0, 1'b1, 10'h000, 0);   // clean access after the abort

    for (int i = 0; i < 40; i++) begin
      int          sel, kind;
      logic [15:0] a;
      sel  = $urandom_range(0, 9);
      kind = $urandom_range(0, 4);
      a = (sel < 6) ? {8'h00, 8'($urandom)} : (sel == 7) ? 16'hFFFE : (sel == 8) ? 16'hFFFD : 16'hFFFF;
      issue(a, 16'($urandom), (kind == 2 || kind == 3), (kind <= 1),
            10'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge Clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
